// File: rtl/gpio_sw_sequencer.sv
// gpio_sw_sequencer: replays a table of switch patterns into a GPIO ATR idle register
module gpio_sw_sequencer #(
  parameter int BASE = 0,
  parameter int ATR_BASE = 0,
  parameter int DEPTH_LOG2 = 4,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   host_set_stb,
  input  logic [7:0]             host_set_addr,
  input  logic [31:0]            host_set_data,
  input  logic                   rx,
  input  logic                   tx,
  output logic                   out_set_stb,
  output logic [7:0]             out_set_addr,
  output logic [31:0]            out_set_data,
  output logic                   busy,
  output logic [DEPTH_LOG2-1:0]  seq_index,
  output logic                   collision
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, DWELL = 2'd2, DONE = 2'd3;
  localparam logic [7:0] CTRL_ADDR = 8'(BASE);
  localparam logic [7:0] DWELL_ADDR = 8'(BASE + 1);
  localparam logic [7:0] TABLE_ADDR = 8'(BASE + 2);
  localparam logic [7:0] ATR_ADDR = 8'(ATR_BASE);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [1:0] state;
  logic enable, one_shot, idle_gate;
  logic [DEPTH_LOG2-1:0] last_index;
  logic [DWELL_WIDTH-1:0] dwell, counter;
  logic [9:0] pat_table [DEPTH];
  logic [9:0] pattern;
  logic pending;
  logic ctrl_wr, dwell_wr, table_wr, gated, issue, load;
  assign ctrl_wr = host_set_stb && host_set_addr == CTRL_ADDR;
  assign dwell_wr = host_set_stb && host_set_addr == DWELL_ADDR;
  assign table_wr = host_set_stb && host_set_addr == TABLE_ADDR;
  assign gated = idle_gate && (rx || tx);
  assign load = enable && state == LOAD;
  assign issue = enable && pending && !host_set_stb;
  assign busy = state != IDLE;
  // host-visible control, dwell and pattern table registers
  always_ff @(posedge clk)
    if (reset) begin
      enable <= 1'b0;
      one_shot <= 1'b0;
      idle_gate <= 1'b0;
      last_index <= '0;
      dwell <= '0;
      for (int i = 0; i < DEPTH; i++) pat_table[i] <= '0;
    end else begin
      if (ctrl_wr) begin
        enable <= host_set_data[0];
        one_shot <= host_set_data[1];
        idle_gate <= host_set_data[2];
        last_index <= host_set_data[8 +: DEPTH_LOG2];
      end
      if (dwell_wr) dwell <= host_set_data[DWELL_WIDTH-1:0];
      if (table_wr) pat_table[host_set_data[16 +: DEPTH_LOG2]] <= host_set_data[9:0];
    end
  // sequencing FSM: load a pattern, dwell on it, then advance or wrap
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      seq_index <= '0;
      counter <= '0;
    end else if (!enable) begin
      state <= IDLE;
      seq_index <= '0;
    end else begin
      case (state)
        IDLE: state <= LOAD;
        LOAD: begin
          counter <= dwell;
          state <= DWELL;
        end
        DWELL:
          if (!gated) begin
            if (|counter) counter <= counter - 1'b1;
            else if (seq_index == last_index) begin
              if (one_shot) state <= DONE;
              else begin
                seq_index <= '0;
                state <= LOAD;
              end
            end else begin
              seq_index <= seq_index + 1'b1;
              state <= LOAD;
            end
          end
        default: state <= DONE;
      endcase
    end
  // pending sequencer write; a reload before issue overwrites it and flags collision
  always_ff @(posedge clk)
    if (reset) begin
      pending <= 1'b0;
      pattern <= '0;
      collision <= 1'b0;
    end else begin
      if (!enable) pending <= 1'b0;
      else if (load) begin
        pending <= 1'b1;
        pattern <= pat_table[seq_index];
      end else if (issue) pending <= 1'b0;
      collision <= ctrl_wr ? 1'b0 : collision | (load && pending && host_set_stb);
    end
  // registered bus merge: host has priority, sequencer fills idle cycles
  always_ff @(posedge clk)
    if (reset) begin
      out_set_stb <= 1'b0;
      out_set_addr <= '0;
      out_set_data <= '0;
    end else begin
      out_set_stb <= host_set_stb || issue;
      if (host_set_stb) begin
        out_set_addr <= host_set_addr;
        out_set_data <= host_set_data;
      end else if (issue) begin
        out_set_addr <= ATR_ADDR;
        out_set_data <= {22'b0, pattern};
      end
    end
endmodule

// File: tb/tb_gpio_sw_sequencer.sv
// tb_gpio_sw_sequencer: directed self-checking bench for gpio_sw_sequencer
module tb_gpio_sw_sequencer;
  localparam int BASE = 16;
  localparam int ATR = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic host_set_stb = 1'b0;
  logic [7:0] host_set_addr = '0;
  logic [31:0] host_set_data = '0;
  logic rx = 1'b0;
  logic tx = 1'b0;
  logic out_set_stb;
  logic [7:0] out_set_addr;
  logic [31:0] out_set_data;
  logic busy;
  logic [3:0] seq_index;
  logic collision;
  int checks = 0;
  int errors = 0;
  logic [9:0] pats [3] = '{10'h001, 10'h002, 10'h004};

  gpio_sw_sequencer #(.BASE(BASE), .ATR_BASE(ATR), .DEPTH_LOG2(4), .DWELL_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .host_set_stb(host_set_stb), .host_set_addr(host_set_addr), .host_set_data(host_set_data),
    .rx(rx), .tx(tx),
    .out_set_stb(out_set_stb), .out_set_addr(out_set_addr), .out_set_data(out_set_data),
    .busy(busy), .seq_index(seq_index), .collision(collision)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    host_set_stb = 1'b1;
    host_set_addr = 8'(a);
    host_set_data = d;
    step();
    host_set_stb = 1'b0;
  endtask

  task automatic wait_seq(input int limit, output int n, output logic [31:0] d);
    n = 0;
    do begin
      step();
      n++;
    end while (!(out_set_stb && out_set_addr == 8'(ATR)) && n < limit);
    d = out_set_data;
  endtask

  initial begin
    int n, cnt;
    logic [31:0] d;
    step();
    step();
    reset = 1'b0;
    check("rst_stb", out_set_stb, 0);
    check("rst_busy", busy, 0);
    check("rst_idx", seq_index, 0);
    check("rst_col", collision, 0);
    check("rst_addr_data", {out_set_addr, out_set_data}, 0);

    wr(8'h05, 32'h3FF);
    check("pass_out", {out_set_stb, out_set_addr, out_set_data}, {1'b1, 8'h05, 32'h3FF});
    check("pass_busy", busy, 0);
    step();
    check("pass_pulse_end", {out_set_stb, out_set_addr}, {1'b0, 8'h05});

    for (int i = 0; i < 3; i++) wr(BASE + 2, (32'(i) << 16) | 32'(pats[i]));
    wr(BASE + 1, 32'd4);
    wr(BASE, 32'h0201);
    wait_seq(50, n, d);
    check("loop_first_lat", n, 3);
    check("loop_first_pat", d, 1);
    check("loop_busy", busy, 1);
    for (int i = 1; i < 5; i++) begin
      wait_seq(50, n, d);
      check("loop_gap", n, 6);
      check("loop_pat", d, 32'(pats[i % 3]));
    end
    wr(BASE, 32'h0);
    step();
    step();
    check("loop_stop_busy", busy, 0);
    check("loop_stop_idx", seq_index, 0);

    wr(BASE, 32'h0203);
    cnt = 0;
    d = '0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_set_stb && out_set_addr == 8'(ATR)) begin
        cnt++;
        d = out_set_data;
      end
    end
    check("oneshot_count", cnt, 3);
    check("oneshot_last_pat", d, 4);
    check("oneshot_busy", busy, 1);
    check("oneshot_idx", seq_index, 2);
    wr(BASE, 32'h0202);
    step();
    check("oneshot_clr_busy", busy, 0);
    check("oneshot_clr_idx", seq_index, 0);

    wr(BASE, 32'h0205);
    wait_seq(50, n, d);
    check("gate_first_pat", d, 1);
    step();
    step();
    rx = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_set_stb) cnt++;
    end
    rx = 1'b0;
    check("gate_quiet", cnt, 0);
    wait_seq(50, n, d);
    check("gate_gap", n + 12, 16);
    check("gate_pat", d, 2);
    wr(BASE, 32'h0);
    step();

    wr(BASE + 1, 32'd0);
    wr(BASE, 32'h0201);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      host_set_stb = 1'b1;
      host_set_addr = 8'h05;
      host_set_data = 32'h100 + 32'(i);
      step();
      if (out_set_stb && out_set_addr == 8'h05 && out_set_data == 32'h100 + 32'(i)) cnt++;
    end
    host_set_stb = 1'b0;
    check("prio_host_never_delayed", cnt, 12);
    step();
    check("prio_deferred_seq", {out_set_stb, out_set_addr}, {1'b1, 8'(ATR)});
    check("col_set", collision, 1);
    wr(BASE, 32'h0);
    check("col_clear", collision, 0);
    step();

    wr(BASE + 1, 32'd4);
    wr(BASE, 32'h0201);
    wait_seq(50, n, d);
    check("rst_run_pat", d, 1);
    step();
    step();
    check("rst_run_busy_before", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_run_out", {out_set_stb, out_set_addr, out_set_data}, 0);
    check("rst_run_busy", busy, 0);
    check("rst_run_idx", seq_index, 0);
    wr(BASE, 32'h1);
    wait_seq(50, n, d);
    check("rst_run_lat", n, 3);
    check("rst_run_cleared_pat", {out_set_stb, out_set_addr, d}, {1'b1, 8'(ATR), 32'h0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
